// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: loadable instruction memory with a one-cycle fetch port.
// Define INSTR_MEM_PARITY_EN to add per-word even parity and parity_err.
module instr_mem_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int PC_W  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic [AW:0]      load_count,
  input  logic             fetch_en,
  input  logic [PC_W-1:0]  pc_A,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             addr_fault,
`ifdef INSTR_MEM_PARITY_EN
  output logic             parity_err,
`endif
  output logic             cpu_hold
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [MW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_idx;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] rd_word;
  logic          accept;
  logic          restart;
  logic          fetch_go;
  logic          fault;
  logic          unused_pc;

  // Only the word-index field of the PC selects a word; higher bits wrap.
  assign rd_idx    = pc_A[AW+1:2];
  assign rd_word   = mem[rd_idx];
  assign fault     = (pc_A[1:0] != 2'b00)
                   || ({1'b0, rd_idx} >= load_count);
  assign unused_pc = ^pc_A;

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;
    restart    = 1'b0;
    accept     = 1'b0;
    fetch_go   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        accept     = load_valid;
        // Last word ends the load, as does filling the final slot.
        if (accept && (load_last || wr_ptr == LAST_IDX)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        cpu_hold = 1'b0;
        if (load_start) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end else begin
          fetch_go = fetch_en;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      load_count  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_valid <= fetch_go;
      if (restart) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (accept) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        load_count <= load_count + CNT_ONE;
      end
      if (fetch_go) begin
        instr      <= fault ? '0 : rd_word[WIDTH-1:0];
        addr_fault <= fault;
      end
    end
  end

`ifdef INSTR_MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= fetch_go && !fault && (^rd_word);
    end
  end
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_word;
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: scoreboard bench for instr_mem_ctrl.
// Uses a DEPTH=256 and a DEPTH=4 instance.
module tb_instr_mem_ctrl;

  localparam int AW  = 8;
  localparam int SAW = 2;

  logic clk;
  logic rst_n;

  logic        load_start, load_valid, load_last, fetch_en;
  logic [31:0] load_data, pc_a;
  logic        load_ready, instr_valid, addr_fault, cpu_hold;
  logic [AW:0] load_count;
  logic [31:0] instr;

  logic         s_load_start, s_load_valid, s_load_last, s_fetch_en;
  logic [31:0]  s_load_data, s_pc_a;
  logic         s_load_ready, s_instr_valid, s_addr_fault, s_cpu_hold;
  logic [SAW:0] s_load_count;
  logic [31:0]  s_instr;

`ifdef INSTR_MEM_PARITY_EN
  logic parity_err, s_parity_err;
`endif

  int tests = 0;
  int fails = 0;

  logic [32:0] sb[$];
  logic [32:0] ss[$];
  logic [32:0] exp_v;
  logic [32:0] got_v;

  logic [31:0] gcd [14] = '{
    32'h00008020, 32'h20100078, 32'h00008820, 32'h201100B4,
    32'h00009020, 32'h12110006, 32'h0211482A, 32'h11200002,
    32'h02308822, 32'h08000005, 32'h02118022, 32'h08000005,
    32'h00109020, 32'hAC120000
  };

  logic [31:0] fact [9] = '{
    32'h20110001, 32'h20100005, 32'h12000004, 32'h02300018,
    32'h00008812, 32'h2210FFFF, 32'h08000002, 32'h00000000,
    32'hAC110000
  };

  logic [31:0] small_w [6] = '{
    32'h11110001, 32'h22220002, 32'h33330003,
    32'h44440004, 32'h55550005, 32'h66660006
  };

  instr_mem_ctrl #(.WIDTH(32), .DEPTH(256), .PC_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .fetch_en    (fetch_en),
    .pc_A        (pc_a),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_fault  (addr_fault),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .cpu_hold    (cpu_hold)
  );

  instr_mem_ctrl #(.WIDTH(32), .DEPTH(4), .PC_W(32)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (s_load_start),
    .load_valid  (s_load_valid),
    .load_data   (s_load_data),
    .load_last   (s_load_last),
    .load_ready  (s_load_ready),
    .load_count  (s_load_count),
    .fetch_en    (s_fetch_en),
    .pc_A        (s_pc_a),
    .instr       (s_instr),
    .instr_valid (s_instr_valid),
    .addr_fault  (s_addr_fault),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err  (s_parity_err),
`endif
    .cpu_hold    (s_cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    tests++;
    if (cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: got %b want 1", cpu_hold);
    end
    tests++;
    if (load_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b want 0", load_ready);
    end
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", instr_valid);
    end
    tests++;
    if (load_count !== '0) begin
      fails++;
      $display("FAIL reset_count: got %0d want 0", load_count);
    end
    tests++;
    if ({addr_fault, instr} !== 33'h0) begin
      fails++;
      $display("FAIL reset_instr: got %b/%h want 0/0", addr_fault, instr);
    end
  endtask

  task automatic test_gcd_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      load_valid = 1'b1;
      load_data  = gcd[i];
      load_last  = (i == 13);
      if (i == 13) begin
        tests++;
        if ({cpu_hold, load_ready} !== 2'b11) begin
          fails++;
          $display("FAIL gcd_loading: hold/ready %b%b want 11",
                   cpu_hold, load_ready);
        end
      end
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tests++;
    if (cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL gcd_hold: got %b want 0", cpu_hold);
    end
    tests++;
    if (load_count !== 9'd14) begin
      fails++;
      $display("FAIL gcd_count: got %0d want 14", load_count);
    end
    pc_a     = 32'h14;
    fetch_en = 1'b1;
    sb.push_back({1'b0, 32'h12110006});
    step();
    fetch_en = 1'b0;
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL gcd_fetch_valid: got %b want 1", instr_valid);
      sb.delete();
    end else begin
      exp_v = sb.pop_front();
      got_v = {addr_fault, instr};
      tests++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL gcd_fetch: got %h want %h", got_v, exp_v);
      end
    end
`ifdef INSTR_MEM_PARITY_EN
    tests++;
    if (parity_err !== 1'b0) begin
      fails++;
      $display("FAIL gcd_parity: got %b want 0", parity_err);
    end
`endif
    step();
    tests++;
    if ({instr_valid, instr} !== {1'b0, 32'h12110006}) begin
      fails++;
      $display("FAIL gcd_hold_out: got %b/%h want 0/12110006",
               instr_valid, instr);
    end
  endtask

  task automatic test_faults();
    logic [31:0] pcs [6] = '{32'h38, 32'h06, 32'h400, 32'h00,
                             32'h34, 32'h36};
    logic [32:0] exps [6] = '{{1'b1, 32'h0}, {1'b1, 32'h0},
                              {1'b0, 32'h00008020},
                              {1'b0, 32'h00008020},
                              {1'b0, 32'hAC120000}, {1'b1, 32'h0}};
    for (int i = 0; i < 6; i++) begin
      pc_a     = pcs[i];
      fetch_en = 1'b1;
      sb.push_back(exps[i]);
      step();
      tests++;
      if (instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL fault_valid[%0d]: got %b want 1", i, instr_valid);
        void'(sb.pop_front());
      end else begin
        exp_v = sb.pop_front();
        got_v = {addr_fault, instr};
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL fault[%0d] pc=%h: got %h want %h",
                   i, pcs[i], got_v, exp_v);
        end
      end
    end
    fetch_en = 1'b0;
    step();
  endtask

  task automatic test_stalled_load();
    int pat [5] = '{1, 0, 0, 1, 1};
    int k = 0;
    int cyc = 0;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    while (k < 9 && cyc < 100) begin
      load_valid = pat[cyc % 5][0];
      load_data  = load_valid ? fact[k] : (32'hDEAD0000 | 32'(cyc));
      load_last  = load_valid ? (k == 8) : 1'b1;
      step();
      if (pat[cyc % 5] == 1) k++;
      cyc++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    tests++;
    if (load_count !== 9'd9 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL stall_done: count %0d hold %b want 9 0",
               load_count, cpu_hold);
    end
    for (int i = 0; i < 10; i++) begin
      pc_a     = 32'(i * 4);
      fetch_en = 1'b1;
      sb.push_back(i < 9 ? {1'b0, fact[i]} : 33'h1_0000_0000);
      step();
      tests++;
      if (instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid);
        void'(sb.pop_front());
      end else begin
        exp_v = sb.pop_front();
        got_v = {addr_fault, instr};
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL stall_read[%0d]: got %h want %h", i, got_v, exp_v);
        end
      end
    end
    fetch_en = 1'b0;
    step();
  endtask

  task automatic test_full_depth();
    s_load_start = 1'b1;
    step();
    s_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1;
      s_load_data  = small_w[i];
      s_load_last  = 1'b0;
      if (i >= 4) begin
        tests++;
        if (s_load_ready !== 1'b0) begin
          fails++;
          $display("FAIL full_ready[%0d]: got %b want 0", i, s_load_ready);
        end
      end
      step();
      if (i == 3) begin
        tests++;
        if ({s_cpu_hold, s_load_count} !== {1'b0, 3'd4}) begin
          fails++;
          $display("FAIL full_run: hold %b count %0d want 0 4",
                   s_cpu_hold, s_load_count);
        end
      end
    end
    s_load_valid = 1'b0;
    tests++;
    if (s_load_count !== 3'd4) begin
      fails++;
      $display("FAIL full_count: got %0d want 4", s_load_count);
    end
    for (int i = 0; i < 3; i++) begin
      s_pc_a     = (i == 0) ? 32'hC : ((i == 1) ? 32'h10 : 32'h4);
      s_fetch_en = 1'b1;
      ss.push_back({1'b0, (i == 0) ? small_w[3]
                          : ((i == 1) ? small_w[0] : small_w[1])});
      step();
      tests++;
      if (s_instr_valid !== 1'b1) begin
        fails++;
        $display("FAIL full_valid[%0d]: got %b want 1", i, s_instr_valid);
        void'(ss.pop_front());
      end else begin
        exp_v = ss.pop_front();
        got_v = {s_addr_fault, s_instr};
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL full_read[%0d]: got %h want %h", i, got_v, exp_v);
        end
      end
    end
    s_fetch_en = 1'b0;
    step();
  endtask

  task automatic test_reload();
    pc_a       = 32'h0;
    fetch_en   = 1'b1;
    load_start = 1'b1;
    step();
    fetch_en   = 1'b0;
    load_start = 1'b0;
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reload_valid: got %b want 0", instr_valid);
    end
    tests++;
    if ({load_ready, cpu_hold, load_count} !== {2'b11, 9'd0}) begin
      fails++;
      $display("FAIL reload_state: ready %b hold %b count %0d want 1 1 0",
               load_ready, cpu_hold, load_count);
    end
    for (int i = 0; i < 4; i++) begin
      load_start = (i == 2);
      load_valid = (i != 2);
      load_data  = 32'hA0000000 | 32'(i);
      load_last  = (i == 3);
      step();
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    tests++;
    if ({cpu_hold, load_count} !== {1'b0, 9'd3}) begin
      fails++;
      $display("FAIL reload_count: hold %b count %0d want 0 3",
               cpu_hold, load_count);
    end
    pc_a     = 32'h8;
    fetch_en = 1'b1;
    sb.push_back({1'b0, 32'hA0000003});
    step();
    fetch_en = 1'b0;
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL reload_fetch_valid: got %b want 1", instr_valid);
      sb.delete();
    end else begin
      exp_v = sb.pop_front();
      got_v = {addr_fault, instr};
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL reload_fetch: got %h want %h", got_v, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({instr_valid, addr_fault, instr, cpu_hold, load_count}
        !== {2'b00, 32'h0, 1'b1, 9'd0}) begin
      fails++;
      $display("FAIL rst_run: valid %b fault %b instr %h hold %b cnt %0d",
               instr_valid, addr_fault, instr, cpu_hold, load_count);
    end
    step();
    rst_n      = 1'b1;
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h12345678;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({load_ready, cpu_hold, load_count} !== {2'b01, 9'd0}) begin
      fails++;
      $display("FAIL rst_load: ready %b hold %b count %0d want 0 1 0",
               load_ready, cpu_hold, load_count);
    end
    load_valid = 1'b0;
    step();
    rst_n    = 1'b1;
    pc_a     = 32'h0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    tests++;
    if ({instr_valid, cpu_hold} !== 2'b01) begin
      fails++;
      $display("FAIL rst_idle_fetch: valid %b hold %b want 0 1",
               instr_valid, cpu_hold);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_last    = 1'b0;
    load_data    = '0;
    fetch_en     = 1'b0;
    pc_a         = '0;
    s_load_start = 1'b0;
    s_load_valid = 1'b0;
    s_load_last  = 1'b0;
    s_load_data  = '0;
    s_fetch_en   = 1'b0;
    s_pc_a       = '0;
    test_reset();
    test_gcd_load();
    test_faults();
    test_stalled_load();
    test_full_depth();
    test_reload();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
